// File: rtl/ppi_bus_control.sv
// CPU-side bus controller for an 8255-style parallel port: strobe synchronisation,
// access FSM, port/control registers, read-back mux and port-buffer enables.
module ppi_bus_control (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cs_n,
  input  logic       rd_n,
  input  logic       wr_n,
  input  logic [1:0] addr,
  input  logic [7:0] din,
  input  logic [7:0] pa_in,
  input  logic [7:0] pb_in,
  input  logic [7:0] pc_in,
  output logic [7:0] dout,
  output logic       dout_en,
  output logic [7:0] pa_out,
  output logic [7:0] pb_out,
  output logic [7:0] pc_out,
  output logic       pa_dir,
  output logic       pb_dir,
  output logic       pcu_dir,
  output logic       pcl_dir,
  output logic       pa_en,
  output logic       pb_en,
  output logic       pc_en,
  output logic       bus_err
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WR_ACT   = 3'd1,
    COMMIT   = 3'd2,
    RD_ACT   = 3'd3,
    CONFLICT = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  rd_sync_q, wr_sync_q;
  logic        rd_dly_q, wr_dly_q;
  logic        rd_s, wr_s, rd_rise, wr_rise;
  logic [1:0]  addr_q;
  logic [7:0]  din_q;
  logic [7:0]  ctrl_q, ctrl_d;
  logic [7:0]  pa_q, pa_d, pb_q, pb_d, pc_q, pc_d;
  logic [7:0]  dout_q, dout_d;
  logic        bus_err_q, bus_err_d;
  logic        in_rd, in_commit, mode_ok;
  logic [7:0]  rd_data;

  assign rd_s    = rd_sync_q[1];
  assign wr_s    = wr_sync_q[1];
  assign rd_rise = rd_s & ~rd_dly_q;
  assign wr_rise = wr_s & ~wr_dly_q;

  // Strobes idle high, so reset the synchronisers to 1: a strobe held low
  // across reset release then shows up as a fresh falling edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_sync_q <= 2'b11;
      wr_sync_q <= 2'b11;
      rd_dly_q  <= 1'b1;
      wr_dly_q  <= 1'b1;
    end else begin
      rd_sync_q <= {rd_sync_q[0], rd_n};
      wr_sync_q <= {wr_sync_q[0], wr_n};
      rd_dly_q  <= rd_s;
      wr_dly_q  <= wr_s;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (!rd_s && !wr_s)      state_d = CONFLICT;
        else if (!wr_s && !cs_n) state_d = WR_ACT;
        else if (!rd_s && !cs_n) state_d = RD_ACT;
      end
      WR_ACT: begin
        if (!rd_s && !wr_s) state_d = CONFLICT;
        else if (wr_rise)   state_d = COMMIT;
      end
      COMMIT:   state_d = IDLE;
      RD_ACT: begin
        if (!rd_s && !wr_s) state_d = CONFLICT;
        else if (rd_rise)   state_d = IDLE;
      end
      CONFLICT: if (rd_s && wr_s) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    in_rd     = (state_q == RD_ACT);
    in_commit = (state_q == COMMIT);
    mode_ok   = (din_q[6:5] == 2'b00) && !din_q[2];
    dout_en   = in_rd;
    pa_en     = ~pa_dir | (in_rd && addr == 2'd0);
    pb_en     = ~pb_dir | (in_rd && addr == 2'd1);
    pc_en     = ~pcu_dir | ~pcl_dir | (in_rd && addr == 2'd2);
    bus_err_d = ((state_d == CONFLICT) && (state_q != CONFLICT)) ||
                (in_commit && addr_q == 2'd3 && din_q[7] && !mode_ok);
  end

  // Address/data are sampled every write-active cycle; the final sample is committed.
  always_ff @(posedge clk) begin
    if (state_q == WR_ACT) begin
      addr_q <= addr;
      din_q  <= din;
    end
  end

  always_comb begin
    case (addr)
      2'd0:    rd_data = pa_dir ? pa_in : pa_q;
      2'd1:    rd_data = pb_dir ? pb_in : pb_q;
      2'd2:    rd_data = {pcu_dir ? pc_in[7:4] : pc_q[7:4],
                          pcl_dir ? pc_in[3:0] : pc_q[3:0]};
      default: rd_data = ctrl_q;
    endcase
  end

  always_comb begin
    ctrl_d = ctrl_q;
    pa_d   = pa_q;
    pb_d   = pb_q;
    pc_d   = pc_q;
    dout_d = in_rd ? rd_data : dout_q;
    if (in_commit) begin
      case (addr_q)
        2'd0: pa_d = din_q;
        2'd1: pb_d = din_q;
        2'd2: pc_d = din_q;
        default: begin
          if (din_q[7]) begin
            if (mode_ok) begin
              ctrl_d = din_q;
              pa_d   = 8'h00;
              pb_d   = 8'h00;
              pc_d   = 8'h00;
            end
          end else begin
            pc_d[din_q[3:1]] = din_q[0];
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q    <= 8'h9B;
      pa_q      <= 8'h00;
      pb_q      <= 8'h00;
      pc_q      <= 8'h00;
      dout_q    <= 8'h00;
      bus_err_q <= 1'b0;
    end else begin
      ctrl_q    <= ctrl_d;
      pa_q      <= pa_d;
      pb_q      <= pb_d;
      pc_q      <= pc_d;
      dout_q    <= dout_d;
      bus_err_q <= bus_err_d;
    end
  end

  assign pa_dir  = ctrl_q[4];
  assign pcu_dir = ctrl_q[3];
  assign pb_dir  = ctrl_q[1];
  assign pcl_dir = ctrl_q[0];
  assign pa_out  = pa_q;
  assign pb_out  = pb_q;
  assign pc_out  = pc_q;
  assign dout    = dout_q;
  assign bus_err = bus_err_q;

endmodule

// File: tb/tb_ppi_bus_control.sv
// Directed bench for ppi_bus_control: reset state, mode set, port writes,
// bit set/reset, read-back muxing, illegal accesses and mid-access reset.
module tb_ppi_bus_control;

  logic       clk = 1'b0;
  logic       rst_n, cs_n, rd_n, wr_n;
  logic [1:0] addr;
  logic [7:0] din, pa_in, pb_in, pc_in;
  logic [7:0] dout, pa_out, pb_out, pc_out;
  logic       dout_en, pa_dir, pb_dir, pcu_dir, pcl_dir, pa_en, pb_en, pc_en, bus_err;

  int vec  = 0;
  int miss = 0;
  int err_pulses = 0;

  ppi_bus_control dut (
    .clk(clk), .rst_n(rst_n), .cs_n(cs_n), .rd_n(rd_n), .wr_n(wr_n),
    .addr(addr), .din(din), .pa_in(pa_in), .pb_in(pb_in), .pc_in(pc_in),
    .dout(dout), .dout_en(dout_en), .pa_out(pa_out), .pb_out(pb_out), .pc_out(pc_out),
    .pa_dir(pa_dir), .pb_dir(pb_dir), .pcu_dir(pcu_dir), .pcl_dir(pcl_dir),
    .pa_en(pa_en), .pb_en(pb_en), .pc_en(pc_en), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (bus_err === 1'b1) err_pulses++;

  task automatic cpu_write(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    addr = a; din = d; cs_n = 1'b0; wr_n = 1'b0;
    repeat (4) @(negedge clk);
    wr_n = 1'b1;
    repeat (6) @(negedge clk);
    cs_n = 1'b1;
  endtask

  task automatic cpu_read(input logic [1:0] a, output logic [7:0] d,
                          output logic en_mid, output logic [2:0] pen_mid);
    @(negedge clk);
    addr = a; cs_n = 1'b0; rd_n = 1'b0;
    repeat (6) @(negedge clk);
    d = dout; en_mid = dout_en; pen_mid = {pa_en, pb_en, pc_en};
    rd_n = 1'b1;
    repeat (4) @(negedge clk);
    cs_n = 1'b1;
  endtask

  task automatic test_reset;
    logic [7:0] d; logic e; logic [2:0] pe;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    vec++; if (dout !== 8'h00) begin miss++; $display("FAIL reset_dout got %h want 00", dout); end
    vec++; if ({pa_dir, pb_dir, pcu_dir, pcl_dir} !== 4'b1111) begin miss++;
      $display("FAIL reset_dir got %b want 1111", {pa_dir, pb_dir, pcu_dir, pcl_dir}); end
    vec++; if ({pa_en, pb_en, pc_en, dout_en, bus_err} !== 5'b0) begin miss++;
      $display("FAIL reset_en got %b want 00000", {pa_en, pb_en, pc_en, dout_en, bus_err}); end
    vec++; if ({pa_out, pb_out, pc_out} !== 24'h0) begin miss++;
      $display("FAIL reset_out got %h want 000000", {pa_out, pb_out, pc_out}); end
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);
    cpu_read(2'd3, d, e, pe);
    vec++; if (d !== 8'h9B) begin miss++; $display("FAIL reset_ctrl_read got %h want 9b", d); end
    vec++; if (e !== 1'b1) begin miss++; $display("FAIL reset_read_dout_en got %b want 1", e); end
    vec++; if (dout_en !== 1'b0) begin miss++; $display("FAIL reset_read_dout_en_after got %b want 0", dout_en); end
  endtask

  task automatic test_mode_and_write;
    cpu_write(2'd1, 8'h5A);
    vec++; if (pb_out !== 8'h5A) begin miss++; $display("FAIL pb_write_input_dir got %h want 5a", pb_out); end
    cpu_write(2'd3, 8'h80);
    vec++; if ({pa_dir, pb_dir, pcu_dir, pcl_dir} !== 4'b0000) begin miss++;
      $display("FAIL mode80_dir got %b want 0000", {pa_dir, pb_dir, pcu_dir, pcl_dir}); end
    vec++; if ({pa_en, pb_en, pc_en} !== 3'b111) begin miss++;
      $display("FAIL mode80_en got %b want 111", {pa_en, pb_en, pc_en}); end
    vec++; if ({pa_out, pb_out, pc_out} !== 24'h0) begin miss++;
      $display("FAIL mode80_clear got %h want 000000", {pa_out, pb_out, pc_out}); end
    @(negedge clk);
    addr = 2'd0; din = 8'h55; cs_n = 1'b0; wr_n = 1'b0;
    repeat (4) @(negedge clk);
    wr_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    vec++; if (pa_out !== 8'h00) begin miss++; $display("FAIL pa_write_early got %h want 00", pa_out); end
    @(posedge clk); #1;
    vec++; if (pa_out !== 8'h55) begin miss++; $display("FAIL pa_write_edge4 got %h want 55", pa_out); end
    repeat (3) @(negedge clk);
    cs_n = 1'b1;
  endtask

  task automatic test_bit_set_reset;
    logic [7:0] d; logic e; logic [2:0] pe;
    cpu_write(2'd3, 8'h0F);
    vec++; if (pc_out !== 8'h80) begin miss++; $display("FAIL bsr_0f got %h want 80", pc_out); end
    cpu_write(2'd3, 8'h07);
    vec++; if (pc_out !== 8'h88) begin miss++; $display("FAIL bsr_07 got %h want 88", pc_out); end
    cpu_write(2'd3, 8'h06);
    vec++; if (pc_out !== 8'h80) begin miss++; $display("FAIL bsr_06 got %h want 80", pc_out); end
    cpu_read(2'd3, d, e, pe);
    vec++; if (d !== 8'h80) begin miss++; $display("FAIL bsr_ctrl_kept got %h want 80", d); end
    vec++; if (pa_out !== 8'h55) begin miss++; $display("FAIL bsr_pa_kept got %h want 55", pa_out); end
    cpu_read(2'd2, d, e, pe);
    vec++; if (d !== 8'h80) begin miss++; $display("FAIL pc_read_out got %h want 80", d); end
  endtask

  task automatic test_pc_nibbles;
    logic [7:0] d; logic e; logic [2:0] pe;
    pc_in = 8'h3C;
    cpu_write(2'd3, 8'h88);
    cpu_write(2'd3, 8'h01);
    vec++; if (pc_out !== 8'h01) begin miss++; $display("FAIL pc_split_out got %h want 01", pc_out); end
    vec++; if (pc_en !== 1'b1) begin miss++; $display("FAIL pc_split_en got %b want 1", pc_en); end
    cpu_read(2'd2, d, e, pe);
    vec++; if (d !== 8'h31) begin miss++; $display("FAIL pc_split_read got %h want 31", d); end
  endtask

  task automatic test_input_read;
    logic [7:0] d; logic e; logic [2:0] pe;
    pa_in = 8'hA5;
    cpu_write(2'd3, 8'h90);
    vec++; if ({pa_en, pb_en, pc_en, dout_en} !== 4'b0110) begin miss++;
      $display("FAIL mode90_idle_en got %b want 0110", {pa_en, pb_en, pc_en, dout_en}); end
    cpu_read(2'd0, d, e, pe);
    vec++; if (d !== 8'hA5) begin miss++; $display("FAIL pa_input_read got %h want a5", d); end
    vec++; if ({e, pe} !== 4'b1111) begin miss++; $display("FAIL pa_read_en got %b want 1111", {e, pe}); end
    vec++; if ({pa_en, dout_en} !== 2'b00) begin miss++;
      $display("FAIL pa_read_en_after got %b want 00", {pa_en, dout_en}); end
  endtask

  task automatic test_illegal;
    logic [7:0] d; logic e; logic [2:0] pe; int base;
    cpu_write(2'd3, 8'h9B);
    cpu_write(2'd0, 8'h12);
    vec++; if (pa_out !== 8'h12) begin miss++; $display("FAIL pa_write_input_dir got %h want 12", pa_out); end
    base = err_pulses;
    cpu_write(2'd3, 8'hC0);
    vec++; if (err_pulses - base !== 1) begin miss++; $display("FAIL err_c0_pulses got %0d want 1", err_pulses - base); end
    base = err_pulses;
    cpu_write(2'd3, 8'h84);
    vec++; if (err_pulses - base !== 1) begin miss++; $display("FAIL err_84_pulses got %0d want 1", err_pulses - base); end
    cpu_read(2'd3, d, e, pe);
    vec++; if (d !== 8'h9B) begin miss++; $display("FAIL err_ctrl_kept got %h want 9b", d); end
    vec++; if (pa_out !== 8'h12) begin miss++; $display("FAIL err_pa_kept got %h want 12", pa_out); end
    base = err_pulses;
    @(negedge clk);
    addr = 2'd0; din = 8'h77; cs_n = 1'b0; rd_n = 1'b0; wr_n = 1'b0;
    repeat (6) @(negedge clk);
    rd_n = 1'b1; wr_n = 1'b1;
    repeat (6) @(negedge clk);
    cs_n = 1'b1;
    vec++; if (err_pulses - base !== 1) begin miss++; $display("FAIL conflict_pulses got %0d want 1", err_pulses - base); end
    vec++; if (pa_out !== 8'h12) begin miss++; $display("FAIL conflict_pa_kept got %h want 12", pa_out); end
    base = err_pulses;
    @(negedge clk);
    addr = 2'd0; din = 8'h77; cs_n = 1'b0; wr_n = 1'b0;
    repeat (5) @(negedge clk);
    rd_n = 1'b0;
    repeat (5) @(negedge clk);
    rd_n = 1'b1; wr_n = 1'b1;
    repeat (8) @(negedge clk);
    cs_n = 1'b1;
    vec++; if (err_pulses - base !== 1) begin miss++; $display("FAIL wr_conflict_pulses got %0d want 1", err_pulses - base); end
    vec++; if (pa_out !== 8'h12) begin miss++; $display("FAIL wr_conflict_discard got %h want 12", pa_out); end
  endtask

  task automatic test_reset_mid_access;
    @(negedge clk);
    addr = 2'd1; din = 8'h33; cs_n = 1'b0; wr_n = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk); wr_n = 1'b1;
    @(negedge clk); rst_n = 1'b1;
    repeat (8) @(negedge clk);
    vec++; if (pb_out !== 8'h00) begin miss++; $display("FAIL rst_mid_write got %h want 00", pb_out); end
    vec++; if ({pa_dir, pb_dir, pcu_dir, pcl_dir} !== 4'b1111) begin miss++;
      $display("FAIL rst_mid_dir got %b want 1111", {pa_dir, pb_dir, pcu_dir, pcl_dir}); end
    wr_n = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    repeat (5) @(negedge clk);
    wr_n = 1'b1;
    repeat (7) @(negedge clk);
    cs_n = 1'b1;
    vec++; if (pb_out !== 8'h33) begin miss++; $display("FAIL rst_held_strobe got %h want 33", pb_out); end
  endtask

  initial begin
    rst_n = 1'b0; cs_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
    addr = 2'd0; din = 8'h00; pa_in = 8'h00; pb_in = 8'h00; pc_in = 8'h00;
    test_reset;
    test_mode_and_write;
    test_bit_set_reset;
    test_pc_nibbles;
    test_input_read;
    test_illegal;
    test_reset_mid_access;
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
